// File: rtl/axi_slave_ram.sv
`default_nettype none
// ============================================================================
// Module   : axi_slave_ram - AXI4 INCR-burst responder over a byte-writable RAM.
//            Define AXI_SLAVE_RAM_DECERR_EN to answer out-of-range bursts with DECERR.
// Revision : 1.0
// ============================================================================
module axi_slave_ram #(
    parameter int AXI_ID_BITWIDTH   = 4,
    parameter int AXI_ADDR_BITWIDTH = 30,
    parameter int AXI_DATA_BITWIDTH = 128,
    parameter int AXI_STRB_BITWIDTH = AXI_DATA_BITWIDTH / 8,
    parameter int MEM_DEPTH         = 1024
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [AXI_ID_BITWIDTH-1:0]   s_axi_awid,
    input  logic [AXI_ADDR_BITWIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]                   s_axi_awlen,
    input  logic [2:0]                   s_axi_awsize,
    input  logic [1:0]                   s_axi_awburst,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [AXI_ID_BITWIDTH-1:0]   s_axi_wid,
    input  logic [AXI_DATA_BITWIDTH-1:0] s_axi_wdata,
    input  logic [AXI_STRB_BITWIDTH-1:0] s_axi_wstrb,
    input  logic                         s_axi_wlast,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [AXI_ID_BITWIDTH-1:0]   s_axi_bid,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [AXI_ID_BITWIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_BITWIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                   s_axi_arlen,
    input  logic [2:0]                   s_axi_arsize,
    input  logic [1:0]                   s_axi_arburst,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [AXI_ID_BITWIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_BITWIDTH-1:0] s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rlast,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready
);
    localparam int OFF_W = $clog2(AXI_STRB_BITWIDTH);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int WA_W  = AXI_ADDR_BITWIDTH - OFF_W;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
`ifdef AXI_SLAVE_RAM_DECERR_EN
    localparam bit DECERR_EN = 1'b1;
`else
    localparam bit DECERR_EN = 1'b0;
`endif

    // A burst is out of range when its last word index reaches past the array.
    function automatic logic out_of_range(input logic [WA_W-1:0] waddr, input logic [7:0] len);
        logic [WA_W:0] last_word;
        last_word = {1'b0, waddr} + (WA_W+1)'(len);
        return DECERR_EN && (last_word >= (WA_W+1)'(MEM_DEPTH));
    endfunction

    logic [AXI_DATA_BITWIDTH-1:0] mem_q [MEM_DEPTH];

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

    wr_state_e                  wr_state_q, wr_state_d;
    logic [AXI_ID_BITWIDTH-1:0] wid_q;
    logic [IDX_W-1:0]           widx_q;
    logic [7:0]                 wlen_q, wcnt_q;
    logic                       wdec_q, awready_q, wready_q, bvalid_q;
    logic [1:0]                 bresp_q;
    logic                       w_aw_hs, w_w_hs, w_w_end, w_b_hs;

    assign w_aw_hs = s_axi_awvalid & awready_q;
    assign w_w_hs  = s_axi_wvalid & wready_q;
    assign w_w_end = w_w_hs & (s_axi_wlast | (wcnt_q == wlen_q));
    assign w_b_hs  = bvalid_q & s_axi_bready;

    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE:  if (w_aw_hs) wr_state_d = W_DATA;
            W_DATA:  if (w_w_end) wr_state_d = W_RESP;
            W_RESP:  if (w_b_hs)  wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) wr_state_q <= W_IDLE;
        else          wr_state_q <= wr_state_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            wid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wdec_q    <= 1'b0;
        end else begin
            awready_q <= (wr_state_d == W_IDLE);
            wready_q  <= (wr_state_d == W_DATA);
            bvalid_q  <= (wr_state_d == W_RESP);
            if (w_aw_hs) begin
                wid_q  <= s_axi_awid;
                widx_q <= s_axi_awaddr[OFF_W +: IDX_W];
                wlen_q <= s_axi_awlen;
                wcnt_q <= '0;
                wdec_q <= out_of_range(s_axi_awaddr[AXI_ADDR_BITWIDTH-1:OFF_W], s_axi_awlen);
            end
            if (w_w_hs) begin
                widx_q <= widx_q + IDX_ONE;
                wcnt_q <= wcnt_q + 8'd1;
            end
            // Terminating on wlast or on the count, whichever first; disagreement is SLVERR.
            if (w_w_end) begin
                if (wdec_q)                                   bresp_q <= RESP_DECERR;
                else if (s_axi_wlast && (wcnt_q == wlen_q))   bresp_q <= RESP_OKAY;
                else                                          bresp_q <= RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_w_hs && !wdec_q) begin
            for (int b = 0; b < AXI_STRB_BITWIDTH; b++) begin
                if (s_axi_wstrb[b]) mem_q[widx_q][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
    end

    rd_state_e                    rd_state_q, rd_state_d;
    logic [AXI_ID_BITWIDTH-1:0]   rid_q;
    logic [IDX_W-1:0]             ridx_q;
    logic [7:0]                   rlen_q, rcnt_q;
    logic                         rdec_q, arready_q, rvalid_q, rlast_q;
    logic [1:0]                   rresp_q;
    logic [AXI_DATA_BITWIDTH-1:0] rdata_q;
    logic                         w_ar_hs, w_r_hs, w_ar_dec;
    logic [IDX_W-1:0]             w_ar_idx;

    assign w_ar_hs  = s_axi_arvalid & arready_q;
    assign w_r_hs   = rvalid_q & s_axi_rready;
    assign w_ar_idx = s_axi_araddr[OFF_W +: IDX_W];
    assign w_ar_dec = out_of_range(s_axi_araddr[AXI_ADDR_BITWIDTH-1:OFF_W], s_axi_arlen);

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (w_ar_hs) rd_state_d = R_DATA;
            R_DATA:  if (w_r_hs && rlast_q) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) rd_state_q <= R_IDLE;
        else          rd_state_q <= rd_state_d;
    end

    // The output register doubles as the one-entry prefetch: it only reloads on a handshake.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rcnt_q    <= '0;
            rdec_q    <= 1'b0;
        end else begin
            arready_q <= (rd_state_d == R_IDLE);
            if (w_ar_hs) begin
                rid_q    <= s_axi_arid;
                rlen_q   <= s_axi_arlen;
                rcnt_q   <= '0;
                ridx_q   <= w_ar_idx + IDX_ONE;
                rdec_q   <= w_ar_dec;
                rresp_q  <= w_ar_dec ? RESP_DECERR : RESP_OKAY;
                rdata_q  <= w_ar_dec ? '0 : mem_q[w_ar_idx];
                rvalid_q <= 1'b1;
                rlast_q  <= (s_axi_arlen == 8'd0);
            end else if (w_r_hs) begin
                if (rlast_q) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                end else begin
                    rdata_q <= rdec_q ? '0 : mem_q[ridx_q];
                    ridx_q  <= ridx_q + IDX_ONE;
                    rcnt_q  <= rcnt_q + 8'd1;
                    rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                end
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = wid_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rdata   = rdata_q;

    logic w_unused;
    assign w_unused = ^{s_axi_wid, s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                        s_axi_awaddr[OFF_W-1:0], s_axi_araddr[OFF_W-1:0]};
endmodule
`default_nettype wire

// File: tb/tb_axi_slave_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_slave_ram - directed self-checking bench for axi_slave_ram.
// Revision : 1.0
// ============================================================================
module tb_axi_slave_ram;
    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic [3:0]   s_axi_awid, s_axi_wid, s_axi_bid, s_axi_arid, s_axi_rid;
    logic [29:0]  s_axi_awaddr, s_axi_araddr;
    logic [7:0]   s_axi_awlen, s_axi_arlen;
    logic [2:0]   s_axi_awsize, s_axi_arsize;
    logic [1:0]   s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic         s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic         s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic         s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [127:0] s_axi_wdata, s_axi_rdata;
    logic [15:0]  s_axi_wstrb;

    axi_slave_ram dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wid(s_axi_wid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wlast(s_axi_wlast), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] rd_data [16];
    logic         rd_last [16];
    logic [1:0]   rd_resp [16];
    logic [3:0]   rd_id;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic write_burst(input logic [29:0] addr, input logic [7:0] len, input int nbeats,
                               input logic [3:0] id, input logic [127:0] d0, input logic [15:0] strb,
                               output logic [1:0] resp, output logic [3:0] bid);
        int k;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awvalid = 1'b1;
        k = 0;
        while (!s_axi_awready && k < 50) begin tick(); k++; end
        chk("awready_wait", s_axi_awready, 1'b1);
        tick();
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            s_axi_wdata = d0 + 128'(i); s_axi_wstrb = strb;
            s_axi_wlast = (i == nbeats - 1); s_axi_wvalid = 1'b1;
            k = 0;
            while (!s_axi_wready && k < 50) begin tick(); k++; end
            chk("wready_wait", s_axi_wready, 1'b1);
            tick();
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
        k = 0;
        while (!s_axi_bvalid && k < 50) begin tick(); k++; end
        chk("bvalid_wait", s_axi_bvalid, 1'b1);
        resp = s_axi_bresp; bid = s_axi_bid;
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic read_burst(input logic [29:0] addr, input logic [7:0] len, input logic [3:0] id,
                              input bit toggle, output int nb);
        int k, cyc;
        bit held;
        logic [127:0] hold_data;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
        k = 0;
        while (!s_axi_arready && k < 50) begin tick(); k++; end
        chk("arready_wait", s_axi_arready, 1'b1);
        tick();
        s_axi_arvalid = 1'b0;
        chk("rvalid_1cyc", s_axi_rvalid, 1'b1);
        nb = 0; cyc = 0; held = 1'b0; hold_data = '0;
        while (nb <= int'(len) && cyc < 100) begin
            s_axi_rready = toggle ? cyc[0] : 1'b1;
            if (held) chk("rdata_hold", s_axi_rdata, hold_data);
            held = 1'b0;
            if (s_axi_rvalid && s_axi_rready) begin
                rd_data[nb] = s_axi_rdata; rd_last[nb] = s_axi_rlast;
                rd_resp[nb] = s_axi_rresp; rd_id = s_axi_rid;
                nb++;
            end else if (s_axi_rvalid) begin
                held = 1'b1; hold_data = s_axi_rdata;
            end
            tick();
            cyc++;
        end
        s_axi_rready = 1'b0;
        chk("beat_count", 128'(nb), 128'(int'(len) + 1));
    endtask

    initial begin
        logic [1:0] resp;
        logic [3:0] bid;
        int nb, k;
        sys_rst = 1'b0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd4;
        s_axi_awburst = 2'b01; s_axi_awvalid = 1'b0; s_axi_wid = '0; s_axi_wdata = '0;
        s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd4;
        s_axi_arburst = 2'b01; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_awready", s_axi_awready, 1'b0);
        chk("rst_wready", s_axi_wready, 1'b0);
        chk("rst_bvalid", s_axi_bvalid, 1'b0);
        chk("rst_arready", s_axi_arready, 1'b0);
        chk("rst_rvalid", s_axi_rvalid, 1'b0);
        chk("rst_rlast", s_axi_rlast, 1'b0);
        chk("rst_bresp", s_axi_bresp, 2'b00);
        chk("rst_rresp", s_axi_rresp, 2'b00);
        chk("rst_bid", s_axi_bid, 4'h0);
        chk("rst_rid", s_axi_rid, 4'h0);
        chk("rst_rdata", s_axi_rdata, 128'h0);
        sys_rst = 1'b1;
        tick();
        chk("idle_awready", s_axi_awready, 1'b1);
        chk("idle_arready", s_axi_arready, 1'b1);

        // 4-beat write then readback
        write_burst(30'h100, 8'd3, 4, 4'h3, 128'd1, 16'hFFFF, resp, bid);
        chk("t1_bresp", resp, 2'b00);
        chk("t1_bid", bid, 4'h3);
        read_burst(30'h100, 8'd3, 4'h5, 1'b0, nb);
        for (int i = 0; i < 4; i++) begin
            chk("t1_rdata", rd_data[i], 128'(i + 1));
            chk("t1_rlast", rd_last[i], (i == 3));
        end
        chk("t1_rid", rd_id, 4'h5);
        chk("t1_rresp", rd_resp[0], 2'b00);

        // partial strobe
        write_burst(30'h200, 8'd0, 1, 4'h1, {128{1'b1}}, 16'hFFFF, resp, bid);
        write_burst(30'h200, 8'd0, 1, 4'h1, 128'h0, 16'h0001, resp, bid);
        read_burst(30'h200, 8'd0, 4'h2, 1'b0, nb);
        chk("t2_rdata", rd_data[0], {{120{1'b1}}, 8'h00});
        chk("t2_rlast", rd_last[0], 1'b1);

        // rready toggling during an 8-beat read
        write_burst(30'h100, 8'd7, 8, 4'h2, 128'h10, 16'hFFFF, resp, bid);
        chk("t3_bresp", resp, 2'b00);
        read_burst(30'h100, 8'd7, 4'h6, 1'b1, nb);
        for (int i = 0; i < 8; i++) begin
            chk("t3_rdata", rd_data[i], 128'h10 + 128'(i));
            chk("t3_rlast", rd_last[i], (i == 7));
        end

        // simultaneous AW and AR to word 5: read-first
        write_burst(30'h50, 8'd0, 1, 4'h1, 128'hA, 16'hFFFF, resp, bid);
        s_axi_awid = 4'h7; s_axi_awaddr = 30'h50; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
        s_axi_arid = 4'h8; s_axi_araddr = 30'h50; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
        chk("t4_awready", s_axi_awready, 1'b1);
        chk("t4_arready", s_axi_arready, 1'b1);
        tick();
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        s_axi_wdata = 128'hB; s_axi_wstrb = 16'hFFFF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
        chk("t4_rvalid", s_axi_rvalid, 1'b1);
        chk("t4_rdata_old", s_axi_rdata, 128'hA);
        k = 0;
        while (!s_axi_wready && k < 50) begin tick(); k++; end
        chk("t4_wready", s_axi_wready, 1'b1);
        tick();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        chk("t4_rdata_stall", s_axi_rdata, 128'hA);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0; s_axi_bready = 1'b1;
        k = 0;
        while (!s_axi_bvalid && k < 50) begin tick(); k++; end
        chk("t4_bvalid", s_axi_bvalid, 1'b1);
        chk("t4_bid", s_axi_bid, 4'h7);
        tick();
        s_axi_bready = 1'b0;
        read_burst(30'h50, 8'd0, 4'h1, 1'b0, nb);
        chk("t4_rdata_new", rd_data[0], 128'hB);

        // early wlast: 2 beats of awlen=3
        write_burst(30'h300, 8'd3, 2, 4'h9, 128'h55, 16'hFFFF, resp, bid);
        chk("t5_bresp", resp, 2'b10);
        chk("t5_bid", bid, 4'h9);
        chk("t5_awready", s_axi_awready, 1'b1);
        chk("t5_wready", s_axi_wready, 1'b0);
        read_burst(30'h300, 8'd1, 4'h1, 1'b0, nb);
        chk("t5_beat0", rd_data[0], 128'h55);
        chk("t5_beat1", rd_data[1], 128'h56);

        // address beyond the array
        write_burst(30'h0, 8'd1, 2, 4'h0, 128'h77, 16'hFFFF, resp, bid);
        read_burst(30'h4000, 8'd1, 4'h4, 1'b0, nb);
`ifdef AXI_SLAVE_RAM_DECERR_EN
        chk("t6_rdata0", rd_data[0], 128'h0);
        chk("t6_rdata1", rd_data[1], 128'h0);
        chk("t6_rresp0", rd_resp[0], 2'b11);
        chk("t6_rresp1", rd_resp[1], 2'b11);
`else
        chk("t6_rdata0", rd_data[0], 128'h77);
        chk("t6_rdata1", rd_data[1], 128'h78);
        chk("t6_rresp0", rd_resp[0], 2'b00);
        chk("t6_rresp1", rd_resp[1], 2'b00);
`endif
        chk("t6_rlast", rd_last[1], 1'b1);

        // reset during beat 2 of an 8-beat read
        s_axi_arid = 4'h4; s_axi_araddr = 30'h100; s_axi_arlen = 8'd7; s_axi_arvalid = 1'b1;
        k = 0;
        while (!s_axi_arready && k < 50) begin tick(); k++; end
        tick();
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        tick();
        tick();
        chk("t7_beat2", s_axi_rdata, 128'h12);
        sys_rst = 1'b0;
        tick();
        s_axi_rready = 1'b0;
        chk("t7_rvalid_rst", s_axi_rvalid, 1'b0);
        chk("t7_arready_rst", s_axi_arready, 1'b0);
        sys_rst = 1'b1;
        tick();
        chk("t7_arready_rel", s_axi_arready, 1'b1);
        chk("t7_rvalid_rel", s_axi_rvalid, 1'b0);
        read_burst(30'h200, 8'd0, 4'h3, 1'b0, nb);
        chk("t7_new_read", rd_data[0], {{120{1'b1}}, 8'h00});
        chk("t7_new_rid", rd_id, 4'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
